// File: rtl/rv32i_lsu_if.sv
// Data-memory port between the load/store unit (master) and memory (slave).
// Latency: none, wires only; a beat completes in the cycle where mem_req and mem_ready are both high.
// Backpressure: memory stalls by holding mem_ready low; the master keeps all request fields stable.
// Signals: mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb driven by the master,
//          mem_ready/mem_rdata driven by the slave (rdata valid with ready on reads).
interface rv32i_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: effective address, one memory beat, load align/extend, register write-back.
// Latency: start -> mem_req next cycle; done/wb_we one cycle after mem_ready (2 cycles minimum).
// Backpressure: memory wait states stretch REQ (bounded by TIMEOUT); busy stalls the core meanwhile.
// Ports: clk/reset (sync, active-high); start/is_load/is_store/funct3/base/offset/store_data/rd_in
//        from decode and register file; mem (rv32i_lsu_if.master) to data memory;
//        wb_we/wb_rd/wb_data to the register file; busy/done/fault/fault_cause to the core.
module rv32i_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_load,
    input  logic               is_store,
    input  logic [2:0]         funct3,
    input  logic [31:0]        base,
    input  logic [31:0]        offset,
    input  logic [31:0]        store_data,
    input  logic [4:0]         rd_in,
    rv32i_lsu_if.master        mem,
    output logic               wb_we,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_data,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_cause
);

    typedef enum logic [1:0] {IDLE, REQ, WB, FLT} state_t;

    // TIMEOUT-1 is the last REQ cycle count that may still see mem_ready.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state, state_nxt;

    logic        op_load;
    logic [2:0]  f3_q;
    logic [1:0]  ea_lo;
    logic [4:0]  rd_q;
    logic [31:0] cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q;
    logic [31:0] wb_data_q;
    logic [1:0]  cause_q;

    logic [31:0] ea;
    logic        illegal;
    logic        misalign;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        timeout_hit;

    assign ea = base + offset;

    // Decode legality and alignment of the request presented at start.
    always_comb begin
        illegal = 1'b0;
        if (is_load == is_store) begin
            illegal = 1'b1;
        end else if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
                default:                                illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: illegal = 1'b0;
                default:                illegal = 1'b1;
            endcase
        end
    end

    // funct3[1:0] encodes the access size for every legal op (00 byte, 01 half, 10 word).
    always_comb begin
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = ea[0];
            2'b10:   misalign = (ea[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
    end

    // Store lane replication: every lane carries the datum, wstrb picks the live ones.
    always_comb begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << ea[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = ea[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = store_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane select and extension from the latched address low bits.
    always_comb begin
        case (ea_lo)
            2'b00:   ld_byte = mem.mem_rdata[7:0];
            2'b01:   ld_byte = mem.mem_rdata[15:8];
            2'b10:   ld_byte = mem.mem_rdata[23:16];
            default: ld_byte = mem.mem_rdata[31:24];
        endcase
        ld_half = ea_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (illegal || misalign) ? FLT : REQ;
                end
            end
            REQ: begin
                // A ready in the final allowed cycle still wins over the timeout.
                if (mem.mem_ready) begin
                    state_nxt = WB;
                end else if (timeout_hit) begin
                    state_nxt = FLT;
                end
            end
            WB:      state_nxt = IDLE;
            FLT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_load   <= 1'b0;
            f3_q      <= 3'd0;
            ea_lo     <= 2'd0;
            rd_q      <= 5'd0;
            cnt       <= 32'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            we_q      <= 1'b0;
            wb_data_q <= 32'd0;
            cause_q   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_load <= is_load;
                        f3_q    <= funct3;
                        ea_lo   <= ea[1:0];
                        rd_q    <= rd_in;
                        cnt     <= 32'd0;
                        cause_q <= illegal ? 2'b10 : (misalign ? 2'b01 : 2'b00);
                        // Bus fields only move when a beat will actually be issued.
                        if (!(illegal || misalign)) begin
                            addr_q  <= {ea[31:2], 2'b00};
                            we_q    <= is_store;
                            wdata_q <= is_store ? st_wdata : 32'd0;
                            wstrb_q <= is_store ? st_wstrb : 4'b0000;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        if (op_load) begin
                            wb_data_q <= ld_ext;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                        if (timeout_hit) begin
                            cause_q <= 2'b11;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = (state == REQ) && we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

    assign wb_we       = (state == WB) && op_load;
    assign wb_rd       = rd_q;
    assign wb_data     = wb_data_q;
    assign busy        = (state != IDLE);
    assign done        = (state == WB) || (state == FLT);
    assign fault       = (state == FLT);
    assign fault_cause = cause_q;

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
Load/store unit for the RV32I core. It takes the base register value and store data read from the register file, forms the effective address, and runs a single ready/valid transaction on the data-memory port. It aligns and sign/zero-extends load data and returns it as a one-cycle write-back (data, rd, write enable) into the register file write port. It stalls the core via busy while a transaction is outstanding.

Parameters:
TIMEOUT, 255, max cycles mem_req may stay high without mem_ready before a timeout fault; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  launch request; sampled only in IDLE
is_load  in  1  operation is a load
is_store  in  1  operation is a store
funct3  in  3  RV32I width/sign code
base  in  32  rs1 value from register file
offset  in  32  sign-extended immediate
store_data  in  32  rs2 value from register file
rd_in  in  5  destination register for loads
mem_req  out  1  memory request valid
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({ea[31:2],2'b00})
mem_wdata  out  32  store data replicated into byte lanes
mem_wstrb  out  4  byte enables (writes); 4'b0000 on reads
mem_ready  in  1  memory accepts/completes the request this cycle
mem_rdata  in  32  read data, valid with mem_ready on reads
wb_we  out  1  register write-back strobe (1-cycle pulse)
wb_rd  out  5  write-back register index
wb_data  out  32  extended load result
busy  out  1  unit not in IDLE
done  out  1  1-cycle completion pulse (load, store or fault)
fault  out  1  1-cycle pulse with done on error
fault_cause  out  2  01 misaligned, 10 illegal op, 11 timeout; held until next start

Behaviour:
- States: IDLE, REQ, WB, FLT.
- Reset: state=IDLE. mem_req, mem_we, wb_we, done, fault, busy=0. mem_addr, mem_wdata, wb_data=0. mem_wstrb=0, wb_rd=0, fault_cause=0. Reset in any state aborts the transaction at once; mem_req drops the cycle after reset is sampled; no write-back occurs.
- IDLE + start: ea = base + offset, mod 2^32, with wrap-around allowed. Latch ea, funct3, rd_in, store_data and the op type.
  - Illegal op goes to FLT with cause 10. Illegal means: is_load==is_store; a load funct3 not in {000,001,010,100,101}; or a store funct3 not in {000,001,010}.
  - Misaligned goes to FLT with cause 01. Misaligned means halfword with ea[0]=1, or word with ea[1:0]!=0.
  - Otherwise go to REQ.
  - start outside IDLE is ignored.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_ready.
  - Byte store: wdata = {4{sd[7:0]}}, wstrb = 1<<ea[1:0].
  - Half store: wdata = {2{sd[15:0]}}, wstrb = ea[1] ? 1100 : 0011.
  - Word store: wstrb = 1111.
  - mem_ready=1: capture mem_rdata and go to WB. mem_req deasserts the next cycle.
  - Timeout: the cycle counter starts at 0 on entering REQ. When the count reaches TIMEOUT with no ready (TIMEOUT!=0), go to FLT with cause 11 and drop mem_req.
- WB (one cycle):
  - Load: wb_we=1, wb_rd=latched rd, wb_data=extended lane.
    - LB/LBU select byte ea[1:0]; LH/LHU select half ea[1].
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - rd=0 is still emitted; the register file discards writes to x0.
  - Store: wb_we=0.
  - done=1; next state IDLE.
- FLT (one cycle): done=1, fault=1, no memory access, no write-back; next state IDLE.
- busy=1 in REQ, WB and FLT.
- Latency: start (cycle 0) gives mem_req in cycle 1. Ready in cycle 1 gives done/wb_we in cycle 2. Minimum is 2 cycles; each wait cycle adds one.
- wb_we and done are registered pulses, never asserted in the same cycle as mem_req.

Test Plan:
- Word load: base=0x1000, offset=4, LW, rd=5; mem_rdata=0xDEADBEEF with ready 1st cycle -> mem_addr=0x1004, wstrb=0; cycle 2 wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, done=1.
- Byte/half extend: ea=0x2003 LB, rdata=0x80FFFFFF -> wb_data=0xFFFFFF80; LBU -> 0x00000080; ea=0x2002 LHU, rdata=0x8001_0000 -> 0x00008001.
- Stores: SB ea=0x3001 sd=0x12345678 -> wdata=0x78787878, wstrb=0010; SH ea=0x3002 -> wstrb=1100, wdata=0x56785678; wb_we stays 0 and done pulses.
- Faults: LW ea=0x1002 -> done+fault cycle 1, cause 01, mem_req never asserted; is_load=is_store=1 -> cause 10.
- Wait states and timeout: ready delayed 3 cycles -> address stable throughout, done at cycle 5. With TIMEOUT=4 and no ready -> fault cause 11; mem_req low afterward.
- Reset mid-REQ and ignored start: assert reset while mem_req=1 -> all outputs 0 next cycle and no wb_we. A start pulse while busy does not change mem_addr.
